multicycle_controller: RTL

Main control unit of the multicycle RV32I core. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath enables and mux selects and produces the 3-bit ALU operation through an ALU-decoder sub-block. It sits between the instruction register and zero flag on one side and the shared PC/memory/ALU/register-file datapath on the other.

---
 rtl/multicycle_controller_pkg.sv | 74 +++++++
 rtl/multicycle_controller_alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle RV32I control unit.
package multicycle_controller_pkg;

  // Major opcodes, instr[6:0].
  typedef enum logic [6:0] {
    OpLoad  = 7'b0000011,
    OpStore = 7'b0100011,
    OpR     = 7'b0110011,
    OpIAlu  = 7'b0010011,
    OpB     = 7'b1100011,
    OpJal   = 7'b1101111,
    OpJalr  = 7'b1100111
  } opcode_t;

  typedef enum logic [1:0] {
    AluOpLoadStore = 2'b00,
    AluOpBranch    = 2'b01,
    AluOpMath      = 2'b10
  } alu_op_t;

  typedef enum logic [2:0] {
    AluAnd = 3'b000,
    AluOr  = 3'b001,
    AluAdd = 3'b010,
    AluSub = 3'b110,
    AluSlt = 3'b111
  } alu_control_t;

  typedef enum logic [1:0] {
    ImmI = 2'b00,
    ImmS = 2'b01,
    ImmB = 2'b10,
    ImmJ = 2'b11
  } imm_src_t;

  localparam logic [1:0] IMM_SRC_B_TYPE = 2'b10;
  localparam logic [1:0] IMM_SRC_J_TYPE = 2'b11;
  localparam logic [2:0] FUN3_BEQ       = 3'b000;

  typedef enum logic [1:0] {
    SrcAPc    = 2'b00,
    SrcAOldPc = 2'b01,
    SrcARs1   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SrcBRs2  = 2'b00,
    SrcBImm  = 2'b01,
    SrcBFour = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ResAluOut    = 2'b00,
    ResReadData  = 2'b01,
    ResAluResult = 2'b10
  } result_src_t;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBeq,
    StJal,
    StJalrAdr,
    StTrap
  } ctrl_state_t;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the coarse ALU operation plus funct fields to an ALU control code.
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  // Decode ALU control; only R-type (op[5]=1) with funct7b5 selects subtract.
  always_comb begin
    o_alu_control = AluAdd;
    unique case (i_alu_op)
      AluOpLoadStore: o_alu_control = AluAdd;
      AluOpBranch:    o_alu_control = AluSub;
      AluOpMath: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? AluSub : AluAdd;
          3'b010:  o_alu_control = AluSlt;
          3'b110:  o_alu_control = AluOr;
          3'b111:  o_alu_control = AluAnd;
          default: o_alu_control = AluAdd;
        endcase
      end
      default: o_alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM of the multicycle RV32I core; drives datapath enables and mux selects.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_imm_src,
  output logic [2:0] o_alu_control,
  output logic       o_reg_write,
  output logic       o_retire,
  output logic       o_illegal
);

  ctrl_state_t r_state;
  ctrl_state_t w_next_state;

  logic [1:0] w_alu_op;
  logic [2:0] w_alu_control;
  logic [1:0] w_imm_src;
  logic [1:0] w_result_src;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_retire;
  logic       w_illegal;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; op/funct are only consulted from DECODE onward.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StFetch: w_next_state = StDecode;
      StDecode: begin
        case (i_op)
          OpLoad, OpStore: w_next_state = StMemAdr;
          OpR:             w_next_state = StExecuteR;
          OpIAlu:          w_next_state = StExecuteI;
          OpB:             w_next_state = (i_funct3 == FUN3_BEQ) ? StBeq : StTrap;
          OpJal:           w_next_state = StJal;
          OpJalr:          w_next_state = StJalrAdr;
          default:         w_next_state = StTrap;
        endcase
      end
      StMemAdr:   w_next_state = (i_op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  w_next_state = StMemWb;
      StMemWb:    w_next_state = StFetch;
      StMemWrite: w_next_state = StFetch;
      StExecuteR: w_next_state = StAluWb;
      StExecuteI: w_next_state = StAluWb;
      StAluWb:    w_next_state = StFetch;
      StBeq:      w_next_state = StFetch;
      StJalrAdr:  w_next_state = StJal;
      StJal:      w_next_state = StAluWb;
      StTrap:     w_next_state = StTrap;
      default:    w_next_state = StFetch;
    endcase
  end

  // Per-state Moore control values before reset gating.
  always_comb begin
    w_alu_op     = AluOpLoadStore;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_result_src = ResAluOut;
    w_src_a      = SrcAPc;
    w_src_b      = SrcBRs2;
    w_reg_write  = 1'b0;
    w_retire     = 1'b0;
    w_illegal    = 1'b0;
    unique case (r_state)
      StFetch: begin
        w_ir_write   = 1'b1;
        w_pc_update  = 1'b1;
        w_src_a      = SrcAPc;
        w_src_b      = SrcBFour;
        w_result_src = ResAluResult;
      end
      StDecode: begin
        w_src_a = SrcAOldPc;
        w_src_b = SrcBImm;
      end
      StMemAdr, StJalrAdr: begin
        w_src_a = SrcARs1;
        w_src_b = SrcBImm;
      end
      StMemRead: w_adr_src = 1'b1;
      StMemWb: begin
        w_result_src = ResReadData;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      StMemWrite: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = 1'b1;
      end
      StExecuteR: begin
        w_src_a  = SrcARs1;
        w_src_b  = SrcBRs2;
        w_alu_op = AluOpMath;
      end
      StExecuteI: begin
        w_src_a  = SrcARs1;
        w_src_b  = SrcBImm;
        w_alu_op = AluOpMath;
      end
      StAluWb: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      StBeq: begin
        w_src_a  = SrcARs1;
        w_src_b  = SrcBRs2;
        w_alu_op = AluOpBranch;
        w_branch = 1'b1;
        w_retire = 1'b1;
      end
      StJal: begin
        w_src_a     = SrcAOldPc;
        w_src_b     = SrcBFour;
        w_pc_update = 1'b1;
      end
      StTrap:  w_illegal = 1'b1;
      default: w_illegal = 1'b0;
    endcase
  end

  // Immediate format depends only on the opcode.
  always_comb begin
    w_imm_src = ImmI;
    case (i_op)
      OpStore: w_imm_src = ImmS;
      OpB:     w_imm_src = IMM_SRC_B_TYPE;
      OpJal:   w_imm_src = IMM_SRC_J_TYPE;
      default: w_imm_src = ImmI;
    endcase
  end

  multicycle_controller_alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (i_funct3),
    .i_op5         (i_op[5]),
    .i_funct7b5    (i_funct7b5),
    .o_alu_control (w_alu_control)
  );

  // Output drive; everything held low while reset is asserted.
  always_comb begin
    o_pc_write    = 1'b0;
    o_adr_src     = 1'b0;
    o_mem_write   = 1'b0;
    o_ir_write    = 1'b0;
    o_result_src  = 2'b00;
    o_alu_src_a   = 2'b00;
    o_alu_src_b   = 2'b00;
    o_imm_src     = 2'b00;
    o_alu_control = 3'b000;
    o_reg_write   = 1'b0;
    o_retire      = 1'b0;
    o_illegal     = 1'b0;
    if (!i_rst) begin
      o_pc_write    = w_pc_update | (w_branch & i_zero);
      o_adr_src     = w_adr_src;
      o_mem_write   = w_mem_write;
      o_ir_write    = w_ir_write;
      o_result_src  = w_result_src;
      o_alu_src_a   = w_src_a;
      o_alu_src_b   = w_src_b;
      o_imm_src     = w_imm_src;
      o_alu_control = w_alu_control;
      o_reg_write   = w_reg_write;
      o_retire      = w_retire;
      o_illegal     = w_illegal;
    end
  end

endmodule
